// File: rtl/uart_tx_arbiter.sv
// Merges NUM_CH same-clock UART TX lines onto one registered TXD pin.
// A channel change waits until both the old and the new line have been idle long enough.
module uart_tx_arbiter #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned BAUD_PERIOD = 104,
    parameter int unsigned IDLE_BITS   = 2,
    parameter int unsigned ACT_STRETCH = 65535,
    localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] tx_in,
    input  logic [SEL_W-1:0]  sel_req,
    output logic              txd,
    output logic [SEL_W-1:0]  sel_cur,
    output logic              switch_pending,
    output logic [NUM_CH-1:0] ch_active
);

    localparam int unsigned IDLE_LIM = IDLE_BITS * BAUD_PERIOD;
    localparam int unsigned CNT_W    = $clog2(IDLE_LIM + 1);
    localparam int unsigned ACT_W    = $clog2(ACT_STRETCH + 1);
    localparam int unsigned PAD_W    = 2 ** SEL_W;
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    localparam logic [1:0] LOCKED = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [SEL_W-1:0]  target;
    logic [SEL_W-1:0]  target_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              pend_n;
    logic [SEL_W-1:0]  sel_n;
    logic              txd_n;

    logic [NUM_CH-1:0] tx_q;
    logic [NUM_CH-1:0] tx_prev;
    logic [PAD_W-1:0]  tx_pad;
    logic              both;
    logic              sel_valid;
    logic [ACT_W-1:0]  act_cnt [NUM_CH];

    // Unused select codes read as idle so indexing is always in range.
    always_comb begin
        tx_pad             = '1;
        tx_pad[NUM_CH-1:0] = tx_q;
    end

    assign both      = tx_pad[sel_cur] & tx_pad[target];
    assign sel_valid = {1'b0, sel_req} < NUM_CH_W;

    // Switch control: cancel beats retarget beats completion.
    always_comb begin
        state_n  = state;
        target_n = target;
        cnt_n    = cnt;
        pend_n   = switch_pending;
        sel_n    = sel_cur;
        txd_n    = tx_pad[sel_cur];
        case (state)
            LOCKED: begin
                if (sel_req != sel_cur && sel_valid) begin
                    target_n = sel_req;
                    cnt_n    = '0;
                    pend_n   = 1'b1;
                    state_n  = DRAIN;
                end
            end
            DRAIN: begin
                cnt_n = both ? cnt + CNT_W'(1) : '0;
                if (sel_req == sel_cur) begin
                    pend_n  = 1'b0;
                    state_n = LOCKED;
                end else if (sel_valid && sel_req != target) begin
                    target_n = sel_req;
                    cnt_n    = '0;
                end else if (both && cnt == CNT_W'(IDLE_LIM - 1)) begin
                    state_n = SWITCH;
                end
            end
            SWITCH: begin
                sel_n   = target;
                txd_n   = 1'b1;
                pend_n  = 1'b0;
                state_n = LOCKED;
            end
            default: begin
                state_n = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= LOCKED;
            target         <= '0;
            cnt            <= '0;
            switch_pending <= 1'b0;
            sel_cur        <= '0;
            txd            <= 1'b1;
        end else begin
            state          <= state_n;
            target         <= target_n;
            cnt            <= cnt_n;
            switch_pending <= pend_n;
            sel_cur        <= sel_n;
            txd            <= txd_n;
        end
    end

    // Input register and retriggerable per-channel activity stretchers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q      <= '1;
            tx_prev   <= '1;
            ch_active <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                act_cnt[i] <= '0;
            end
        end else begin
            tx_q    <= tx_in;
            tx_prev <= tx_q;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (tx_prev[i] && !tx_q[i]) begin
                    act_cnt[i] <= ACT_W'(ACT_STRETCH);
                end else if (act_cnt[i] != '0) begin
                    act_cnt[i] <= act_cnt[i] - ACT_W'(1);
                end
                ch_active[i] <= (act_cnt[i] != '0);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a timestamp-based model checked every cycle, plus
// hand-computed checks of latency, switch timing, frame integrity and activity.
module tb_uart_tx_arbiter;

    localparam int N    = 3;
    localparam int BP   = 4;
    localparam int IB   = 2;
    localparam int S    = 16;
    localparam int LIM  = IB * BP;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] tx_in;
    logic [1:0] sel_req;
    logic       txd;
    logic [1:0] sel_cur;
    logic       switch_pending;
    logic [2:0] ch_active;

    logic [0:0] tx_in1;
    logic [0:0] sel_req1;
    logic       txd1;
    logic [0:0] sel_cur1;
    logic       pend1;
    logic [0:0] ch_active1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // model state
    int         n;
    logic [2:0] d1, d2;
    int         m_cur, m_tgt, quiet_since;
    bit         m_pend, m_sw;
    int         lf [N];
    int         pf [N];
    logic       exp_txd;
    logic [2:0] exp_act;

    uart_tx_arbiter #(.NUM_CH(N), .BAUD_PERIOD(BP), .IDLE_BITS(IB), .ACT_STRETCH(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .tx_in(tx_in), .sel_req(sel_req), .txd(txd),
        .sel_cur(sel_cur), .switch_pending(switch_pending), .ch_active(ch_active)
    );

    uart_tx_arbiter #(.NUM_CH(1), .BAUD_PERIOD(BP), .IDLE_BITS(IB), .ACT_STRETCH(S)) u_one (
        .clk(clk), .reset_n(reset_n), .tx_in(tx_in1), .sel_req(sel_req1), .txd(txd1),
        .sel_cur(sel_cur1), .switch_pending(pend1), .ch_active(ch_active1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; d1 = '1; d2 = '1;
        m_cur = 0; m_tgt = 0; quiet_since = 0; m_pend = 0; m_sw = 0;
        for (int i = 0; i < N; i++) begin lf[i] = -100000; pf[i] = -100000; end
        exp_txd = 1'b1; exp_act = '0;
    endtask

    // One clock of the model: d1 is what the arbiter sees, d2 the sample before it.
    task automatic model_tick(input logic [2:0] tin, input int sreq);
        logic [2:0] line;
        bit quiet;
        n++;
        line = d1;
        for (int i = 0; i < N; i++) begin
            if (d2[i] && !line[i]) begin pf[i] = lf[i]; lf[i] = n; end
            exp_act[i] = ((n - lf[i] >= 1) && (n - lf[i] <= S)) ||
                         ((n - pf[i] >= 1) && (n - pf[i] <= S));
        end
        if (m_sw) begin
            exp_txd = 1'b1; m_cur = m_tgt; m_pend = 0; m_sw = 0;
        end else begin
            exp_txd = line[m_cur];
            if (!m_pend) begin
                if (sreq != m_cur && sreq < N) begin
                    m_pend = 1; m_tgt = sreq; quiet_since = n + 1;
                end
            end else begin
                quiet = line[m_cur] && line[m_tgt];
                if (sreq == m_cur) m_pend = 0;
                else if (sreq < N && sreq != m_tgt) begin m_tgt = sreq; quiet_since = n + 1; end
                else if (!quiet) quiet_since = n + 1;
                else if (n - quiet_since + 1 >= LIM) m_sw = 1;
            end
        end
        d2 = d1; d1 = tin;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_tick(tx_in, int'(sel_req));
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd", 32'(txd), 32'(exp_txd));
            check("sel_cur", 32'(sel_cur), 32'(m_cur));
            check("switch_pending", 32'(switch_pending), 32'(m_pend));
            check("ch_active", 32'(ch_active), 32'(exp_act));
            check("one_sel_cur", 32'(sel_cur1), 32'(0));
            check("one_pending", 32'(pend1), 32'(0));
        end
    end

    initial begin
        logic [9:0] frame;
        logic [9:0] got;
        logic [S+16:0] act1;
        int s;
        int sw_step;

        reset_n = 1'b0; tx_in = '1; sel_req = '0; tx_in1 = 1'b1; sel_req1 = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'(1));
        check("rst_sel_cur", 32'(sel_cur), 32'(0));
        check("rst_pending", 32'(switch_pending), 32'(0));
        check("rst_ch_active", 32'(ch_active), 32'(0));
        reset_n = 1'b1;

        // pass-through latency
        step(); step();
        tx_in[0] = 1'b0; tx_in1 = 1'b0;
        step();
        check("lat1_txd", 32'(txd), 32'(1));
        check("one_lat1_txd", 32'(txd1), 32'(1));
        step();
        check("lat2_txd", 32'(txd), 32'(0));
        check("one_lat2_txd", 32'(txd1), 32'(0));
        tx_in[0] = 1'b1; tx_in1 = 1'b1;
        repeat (4) step();

        // idle switch 0 -> 1
        sel_req = 2'd1;
        step();
        check("sw_pending", 32'(switch_pending), 32'(1));
        repeat (8) step();
        check("sw_not_yet", 32'(sel_cur), 32'(0));
        check("sw_mark", 32'(txd), 32'(1));
        step();
        check("sw_done", 32'(sel_cur), 32'(1));

        // cancel while draining, with traffic on the current line
        sel_req = 2'd0; tx_in[1] = 1'b0;
        repeat (3) step();
        check("cancel_pend_before", 32'(switch_pending), 32'(1));
        sel_req = 2'd1; tx_in[1] = 1'b1;
        step();
        check("cancel_pend_after", 32'(switch_pending), 32'(0));
        repeat (12) step();
        check("cancel_sel_cur", 32'(sel_cur), 32'(1));

        // out-of-range request
        sel_req = 2'd3;
        repeat (4) step();
        check("oor_pending", 32'(switch_pending), 32'(0));
        check("oor_sel_cur", 32'(sel_cur), 32'(1));

        // retarget mid-drain restarts the idle count
        sel_req = 2'd0;
        step();
        check("rt_pending", 32'(switch_pending), 32'(1));
        repeat (3) step();
        sel_req = 2'd2;
        repeat (9) step();
        check("rt_not_yet", 32'(sel_cur), 32'(1));
        step();
        check("rt_done", 32'(sel_cur), 32'(2));
        sel_req = 2'd0;
        repeat (12) step();
        check("back_to_0", 32'(sel_cur), 32'(0));

        // 0x55 frame on channel 0 while a switch to 1 is requested at the start bit
        frame = {1'b1, 8'h55, 1'b0};
        got = '0; s = 0; sw_step = -1;
        sel_req = 2'd1;
        for (int b = 0; b < 10; b++) begin
            tx_in[0] = frame[b];
            for (int k = 0; k < BP; k++) begin
                step(); s++;
                if (s % BP == 0) got[s / BP - 1] = txd;
                if (sw_step < 0 && sel_cur == 2'd1) sw_step = s;
            end
        end
        tx_in[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(); s++;
            if (sw_step < 0 && sel_cur == 2'd1) sw_step = s;
        end
        check("frame_bits", 32'(got), 32'(10'h2AA));
        check("frame_sw_step", 32'(sw_step), 32'(46));

        // activity stretch on channel 1 with a retrigger
        act1 = '0;
        for (int k = 1; k <= 32; k++) begin
            tx_in[1] = !(k == 1 || k == 2 || k == 11 || k == 12);
            step();
            act1[k] = ch_active[1];
        end
        check("act_s2", 32'(act1[2]), 32'(0));
        check("act_s3", 32'(act1[3]), 32'(1));
        check("act_s19", 32'(act1[19]), 32'(1));
        check("act_s28", 32'(act1[28]), 32'(1));
        check("act_s29", 32'(act1[29]), 32'(0));

        // reset while draining abandons the switch
        sel_req = 2'd0;
        repeat (3) step();
        check("rd_pending", 32'(switch_pending), 32'(1));
        #1;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("rd_sel_cur", 32'(sel_cur), 32'(0));
        check("rd_pend", 32'(switch_pending), 32'(0));
        reset_n = 1'b1;
        repeat (12) step();
        check("rd_after_sel_cur", 32'(sel_cur), 32'(0));
        check("rd_after_pend", 32'(switch_pending), 32'(0));

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Parametrised successor to the fixed two-source debug/CPU UART TX select register.
- Merges NUM_CH same-clock UART TX sources (CPU, OCD, future peripherals) onto one TXD pin.
- Channel changes take effect only at a verified idle gap on both the old and new lines, so no frame is truncated or spliced.
- Provides per-channel stretched activity flags for status LEDs.

Parameters:
NUM_CH, 2, number of TX sources (>=1)
BAUD_PERIOD, 104, clk cycles per UART bit
IDLE_BITS, 2, bit-times both lines must be continuously high before a switch
ACT_STRETCH, 65535, clk cycles an activity flag stays high after a start bit
SEL_W, derived = max(1, clog2(NUM_CH)), select width (localparam, not overridable)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tx_in  input  NUM_CH  UART TX lines; bit i = channel i; idle high
sel_req  input  SEL_W  requested channel; level, may change any cycle
txd  output  1  registered merged TX line
sel_cur  output  SEL_W  channel currently driving txd
switch_pending  output  1  high while a requested switch waits for idle
ch_active  output  NUM_CH  per-channel stretched activity flag

Behaviour:
- Reset values (async on reset_n low): txd=1, sel_cur=0, switch_pending=0, ch_active=0, state=LOCKED, idle counter=0, target=0, input register=all 1s.
- Input stage: tx_in registered once into tx_q. txd <= tx_q[sel_cur]. Pass-through latency is 2 clk from tx_in to txd.
- Idle counter width: clog2(IDLE_BITS*BAUD_PERIOD+1). IDLE_LIM = IDLE_BITS*BAUD_PERIOD.
- State LOCKED:
  - Forward the current channel.
  - If sel_req != sel_cur and sel_req < NUM_CH: target <= sel_req, counter <= 0, switch_pending <= 1, go to DRAIN.
  - Out-of-range sel_req is ignored.
- State DRAIN:
  - Still forward sel_cur.
  - Counter increments each cycle that tx_q[sel_cur]==1 and tx_q[target]==1; clears to 0 on any cycle where either is low.
  - If sel_req == sel_cur: cancel, switch_pending <= 0, go to LOCKED.
  - Else if sel_req is valid and != target: target <= sel_req, counter <= 0, stay in DRAIN.
  - Else if counter == IDLE_LIM-1 and both lines are high this cycle: go to SWITCH.
  - Priority: cancel > retarget > complete.
- State SWITCH (exactly 1 cycle):
  - sel_cur <= target, txd <= 1 (forced mark), switch_pending <= 0, go to LOCKED.
  - txd follows the new channel from the next cycle.
- Activity:
  - On a falling edge of tx_q[i] (start bit), the per-channel counter reloads ACT_STRETCH; otherwise it decrements to 0.
  - ch_active[i] = (counter != 0), registered.
  - Activity tracks all channels regardless of selection.
  - A new falling edge while active reloads (retriggerable).
- NUM_CH=1: SEL_W=1; sel_req=1 is out of range and ignored; the block is pure pass-through plus activity.
- Reset mid-DRAIN: the switch is abandoned and sel_cur returns to 0.
- A channel held low (break) stalls the switch indefinitely. This is intended; software cancels by restoring sel_req.

Test Plan:
- Reset, NUM_CH=2, both tx_in high -> txd=1, sel_cur=0, switch_pending=0, ch_active=0; drive tx_in[0] low at cycle t -> txd low at t+2.
- Both lines idle, sel_req 0->1 at cycle t -> switch_pending=1 at t+1; sel_cur=1 exactly IDLE_LIM+2 cycles after t (BAUD_PERIOD=4, IDLE_BITS=2: t+10); txd=1 in the SWITCH cycle.
- Channel 0 sending byte 0x55 (BAUD_PERIOD=4), sel_req->1 at start bit -> all 10 bits appear intact on txd; sel_cur changes only after stop bit plus 8 idle cycles.
- During DRAIN set sel_req back to 0 -> switch_pending drops next cycle, sel_cur stays 0, no txd glitch.
- NUM_CH=3, sel_req=3 -> ignored, switch_pending stays 0; then sel_req=1 followed by 2 mid-DRAIN -> counter restarts and final sel_cur=2.
- ACT_STRETCH=16: one start bit on tx_in[1] -> ch_active[1] high for 16 cycles, then low; second start bit at cycle 10 -> high until cycle 26 relative to the first edge.
